// File: rtl/ram_ctrl_pkg.sv
// rtl/ram_ctrl_pkg.sv - shared types, width codes and FSM encodings for the RAM controller
package ram_ctrl_pkg;

  localparam int DATA_W     = 32;
  localparam int DATA_BYTES = DATA_W / 8;

  localparam logic [1:0] WIDTH_BYTE = 2'd0;
  localparam logic [1:0] WIDTH_HALF = 2'd1;
  localparam logic [1:0] WIDTH_WORD = 2'd2;

  typedef enum logic [1:0] {
    RAM_IDLE  = 2'd0,
    RAM_READ  = 2'd1,
    RAM_WRITE = 2'd2
  } ram_state_e;

  // Width code 3 is treated as a full word.
  function automatic int width_bytes(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: return 1;
      WIDTH_HALF: return 2;
      WIDTH_WORD: return 4;
      default:    return 4;
    endcase
  endfunction

endpackage

// File: rtl/ram_ctrl_if.sv
// rtl/ram_ctrl_if.sv - IF fetch, MEM load/store and byte RAM signals of the RAM controller
interface ram_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32
) ();

  logic              if_read;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_data;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_width;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;

  logic [ADDR_W-1:0] ram_a;
  logic              ram_wr;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport slave (
    input  if_read, if_addr, mem_read, mem_write, mem_addr, mem_width, mem_wdata, ram_din,
    output if_ready, if_data, mem_ready, mem_rdata, ram_a, ram_wr, ram_dout
  );

  modport master (
    output if_read, if_addr, mem_read, mem_write, mem_addr, mem_width, mem_wdata, ram_din,
    input  if_ready, if_data, mem_ready, mem_rdata, ram_a, ram_wr, ram_dout
  );

endinterface

// File: rtl/ram_byte_asm.sv
// rtl/ram_byte_asm.sv - byte-lane capture register with n-byte assembly and zero-extension
module ram_byte_asm #(
  parameter int LANES = 4,
  parameter int CNT_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     cap_en,
  input  logic [$clog2(LANES)-1:0] cap_lane,
  input  logic                     last,
  input  logic [CNT_W-1:0]         n,
  input  logic [7:0]               din,
  output logic [8*LANES-1:0]       data
);

  logic [7:0] lane_q [LANES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
    end else if (clear) begin
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
    end else if (cap_en) begin
      lane_q[cap_lane] <= din;
    end
  end

  // The final lane comes straight from the RAM's output register in the ready cycle.
  always_comb begin
    data = '0;
    if (last) begin
      for (int k = 0; k < LANES; k++) begin
        if (CNT_W'(k + 1) < n)       data[8*k +: 8] = lane_q[k];
        else if (CNT_W'(k + 1) == n) data[8*k +: 8] = din;
      end
    end
  end

endmodule

// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - arbitrates IF fetches and MEM loads/stores onto a byte-wide synchronous RAM
module ram_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  ram_ctrl_if.slave bus
);

  localparam int CNT_W  = $clog2(WORD_BYTES) + 1;
  localparam int LANE_W = $clog2(DATA_BYTES);

  ram_state_e        state;
  logic [ADDR_W-1:0] base;
  logic [CNT_W-1:0]  n;
  logic [CNT_W-1:0]  cnt;
  logic              is_if;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] ram_a_q;
  logic              ram_wr_q;
  logic [7:0]        ram_dout_q;
  logic              if_ready_q;
  logic              mem_ready_q;

  logic [CNT_W-1:0]  mem_n;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              mem_req;
  logic              if_abort;
  logic              rd_done;
  logic [DATA_W-1:0] asm_data;

  assign mem_n    = CNT_W'(width_bytes(bus.mem_width));
  assign cnt_nxt  = cnt + CNT_W'(1);
  assign mem_req  = bus.mem_read | bus.mem_write;
  assign if_abort = is_if && (!bus.if_read || (bus.if_addr != base));
  assign rd_done  = (state == RAM_READ) && (if_ready_q || mem_ready_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RAM_IDLE;
      base        <= '0;
      n           <= '0;
      cnt         <= '0;
      is_if       <= 1'b0;
      wdata       <= '0;
      ram_a_q     <= '0;
      ram_wr_q    <= 1'b0;
      ram_dout_q  <= '0;
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
    end else begin
      if_ready_q  <= 1'b0;
      mem_ready_q <= 1'b0;
      case (state)
        RAM_IDLE: begin
          cnt <= CNT_W'(1);
          if (mem_req) begin
            base    <= bus.mem_addr;
            n       <= mem_n;
            is_if   <= 1'b0;
            wdata   <= bus.mem_wdata;
            ram_a_q <= bus.mem_addr;
            if (bus.mem_write) begin
              state       <= RAM_WRITE;
              ram_wr_q    <= 1'b1;
              ram_dout_q  <= bus.mem_wdata[7:0];
              mem_ready_q <= (mem_n == CNT_W'(1));
            end else begin
              state <= RAM_READ;
            end
          end else if (bus.if_read) begin
            state   <= RAM_READ;
            base    <= bus.if_addr;
            n       <= CNT_W'(WORD_BYTES);
            is_if   <= 1'b1;
            ram_a_q <= bus.if_addr;
          end
        end
        RAM_READ: begin
          if (rd_done) begin
            state <= RAM_IDLE;
          end else if (if_abort) begin
            state   <= RAM_IDLE;
            ram_a_q <= '0;
          end else if (cnt < n) begin
            ram_a_q <= base + ADDR_W'(cnt);
            cnt     <= cnt_nxt;
          end else begin
            // Last address went out this cycle; its byte lands with the ready pulse.
            ram_a_q     <= '0;
            if_ready_q  <= is_if;
            mem_ready_q <= !is_if;
          end
        end
        RAM_WRITE: begin
          if (cnt < n) begin
            ram_a_q     <= base + ADDR_W'(cnt);
            ram_dout_q  <= wdata[{cnt[1:0], 3'b000} +: 8];
            cnt         <= cnt_nxt;
            mem_ready_q <= (cnt_nxt == n);
          end else begin
            state      <= RAM_IDLE;
            ram_a_q    <= '0;
            ram_wr_q   <= 1'b0;
            ram_dout_q <= '0;
          end
        end
        default: state <= RAM_IDLE;
      endcase
    end
  end

  ram_byte_asm #(
    .LANES (DATA_BYTES),
    .CNT_W (CNT_W)
  ) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (state == RAM_IDLE),
    .cap_en   ((state == RAM_READ) && !rd_done && (cnt >= CNT_W'(2))),
    .cap_lane (LANE_W'(cnt - CNT_W'(2))),
    .last     (rd_done),
    .n        (n),
    .din      (bus.ram_din),
    .data     (asm_data)
  );

  assign bus.ram_a     = ram_a_q;
  assign bus.ram_wr    = ram_wr_q;
  assign bus.ram_dout  = ram_dout_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.mem_ready = mem_ready_q;
  assign bus.if_data   = is_if ? asm_data : '0;
  assign bus.mem_rdata = is_if ? '0 : asm_data;

endmodule

// File: tb/tb_ram_ctrl.sv
// tb/tb_ram_ctrl.sv - directed self-checking bench for ram_ctrl with a 1-cycle byte RAM model
module tb_ram_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_ctrl_if #(.ADDR_W(32)) bus ();

  ram_ctrl #(.ADDR_W(32), .WORD_BYTES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [8192];
  always @(posedge clk) begin
    if (bus.ram_wr) mem[bus.ram_a[12:0]] <= bus.ram_dout;
    bus.ram_din <= mem[bus.ram_a[12:0]];
  end

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int at = 0;
  logic [31:0] hist_a [32];
  logic        hist_wr [32];
  logic [7:0]  hist_dout [32];
  logic [7:0]  st_bytes [4];
  logic [31:0] wrap_a [4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (cyc < 32) begin
      hist_a[cyc]    = bus.ram_a;
      hist_wr[cyc]   = bus.ram_wr;
      hist_dout[cyc] = bus.ram_dout;
    end
  endtask

  task automatic start();
    @(negedge clk);
    cyc = 1;
  endtask

  task automatic wait_ready(input bit use_if, output int found);
    found = 0;
    for (int i = 0; i < 24 && found == 0; i++) begin
      step();
      if (use_if ? bus.if_ready : bus.mem_ready) found = cyc;
    end
  endtask

  initial begin
    bus.if_read = 1'b0;  bus.if_addr = '0;
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_addr = '0;
    bus.mem_width = 2'd0; bus.mem_wdata = '0;
    st_bytes = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    wrap_a = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001};
    for (int i = 0; i < 8192; i++) mem[i] <= 8'h00;
    mem[13'h1000] <= 8'h13; mem[13'h1001] <= 8'h05; mem[13'h1002] <= 8'h10; mem[13'h1003] <= 8'h00;
    mem[13'h0007] <= 8'h5A;
    mem[13'h0100] <= 8'h11; mem[13'h0101] <= 8'h22; mem[13'h0102] <= 8'h33; mem[13'h0103] <= 8'h44;
    mem[13'h0200] <= 8'hAA; mem[13'h0201] <= 8'hBB; mem[13'h0202] <= 8'hCC; mem[13'h0203] <= 8'hDD;
    mem[13'h1FFE] <= 8'h01; mem[13'h1FFF] <= 8'h02; mem[13'h0000] <= 8'h03; mem[13'h0001] <= 8'h04;

    repeat (3) @(negedge clk);
    check("rst_ram_a", bus.ram_a, 32'h0);
    check("rst_ram_wr", 32'(bus.ram_wr), 32'h0);
    check("rst_ram_dout", 32'(bus.ram_dout), 32'h0);
    check("rst_if_ready", 32'(bus.if_ready), 32'h0);
    check("rst_mem_ready", 32'(bus.mem_ready), 32'h0);
    check("rst_if_data", bus.if_data, 32'h0);
    check("rst_mem_rdata", bus.mem_rdata, 32'h0);
    rst_n = 1'b1;

    // IF fetch of one word
    start(); bus.if_read = 1'b1; bus.if_addr = 32'h1000;
    wait_ready(1'b1, at);
    check("if_latency", 32'(at), 32'd6);
    check("if_data", bus.if_data, 32'h0010_0513);
    check("if_addr_first", hist_a[2], 32'h1000);
    check("if_addr_last", hist_a[5], 32'h1003);
    bus.if_read = 1'b0;
    step();
    check("if_ready_pulse", 32'(bus.if_ready), 32'h0);
    check("if_data_after", bus.if_data, 32'h0);

    // Word store, then half and width-3 loads back
    start(); bus.mem_write = 1'b1; bus.mem_addr = 32'h20; bus.mem_width = 2'd2;
    bus.mem_wdata = 32'hDEAD_BEEF;
    wait_ready(1'b0, at);
    check("st_latency", 32'(at), 32'd5);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("st_wr%0d", k), 32'(hist_wr[k+2]), 32'h1);
      check($sformatf("st_byte%0d", k), 32'(hist_dout[k+2]), 32'(st_bytes[k]));
      check($sformatf("st_addr%0d", k), hist_a[k+2], 32'h20 + 32'(k));
    end
    check("st_rdata_zero", bus.mem_rdata, 32'h0);
    bus.mem_write = 1'b0;
    step();
    check("st_wr_idle", 32'(bus.ram_wr), 32'h0);
    check("st_ready_pulse", 32'(bus.mem_ready), 32'h0);

    start(); bus.mem_read = 1'b1; bus.mem_addr = 32'h22; bus.mem_width = 2'd1;
    wait_ready(1'b0, at);
    check("ld_half_latency", 32'(at), 32'd4);
    check("ld_half_data", bus.mem_rdata, 32'h0000_DEAD);
    bus.mem_read = 1'b0;
    step();
    check("ld_half_after", bus.mem_rdata, 32'h0);

    start(); bus.mem_read = 1'b1; bus.mem_addr = 32'h20; bus.mem_width = 2'd3;
    wait_ready(1'b0, at);
    check("ld_w3_latency", 32'(at), 32'd6);
    check("ld_w3_data", bus.mem_rdata, 32'hDEAD_BEEF);
    bus.mem_read = 1'b0;
    step();

    // Simultaneous IF and MEM byte load: MEM first
    start(); bus.if_read = 1'b1; bus.if_addr = 32'h1000;
    bus.mem_read = 1'b1; bus.mem_addr = 32'h7; bus.mem_width = 2'd0;
    wait_ready(1'b0, at);
    check("arb_mem_latency", 32'(at), 32'd3);
    check("arb_mem_data", bus.mem_rdata, 32'h0000_005A);
    check("arb_if_quiet", 32'(bus.if_ready), 32'h0);
    check("arb_addr_c2", hist_a[2], 32'h7);
    check("arb_addr_c3", hist_a[3], 32'h0);
    bus.mem_read = 1'b0;
    wait_ready(1'b1, at);
    check("arb_if_latency", 32'(at), 32'd9);
    check("arb_if_data", bus.if_data, 32'h0010_0513);
    bus.if_read = 1'b0;
    step();

    // IF abort on address change, then re-fetch
    start(); bus.if_read = 1'b1; bus.if_addr = 32'h100;
    step(); step();
    bus.if_addr = 32'h200;
    wait_ready(1'b1, at);
    check("abort_latency", 32'(at), 32'd9);
    check("abort_data", bus.if_data, 32'hDDCC_BBAA);
    bus.if_read = 1'b0;
    step();

    // Reset in the middle of a word store
    start(); bus.mem_write = 1'b1; bus.mem_addr = 32'h40; bus.mem_width = 2'd2;
    bus.mem_wdata = 32'h1122_3344;
    step(); step(); step();
    check("rstw_wr_before", 32'(bus.ram_wr), 32'h1);
    check("rstw_byte2", 32'(bus.ram_dout), 32'h22);
    rst_n = 1'b0; bus.mem_write = 1'b0;
    #1;
    check("rstw_wr_async", 32'(bus.ram_wr), 32'h0);
    check("rstw_addr", bus.ram_a, 32'h0);
    check("rstw_no_ready", 32'(bus.mem_ready), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rstw_no_ready_late", 32'(bus.mem_ready), 32'h0);
    start(); bus.mem_read = 1'b1; bus.mem_addr = 32'h40; bus.mem_width = 2'd2;
    wait_ready(1'b0, at);
    check("rstw_ld_latency", 32'(at), 32'd6);
    check("rstw_ld_data", bus.mem_rdata, 32'h0000_3344);
    bus.mem_read = 1'b0;
    step();

    // Address wrap at the top of the space
    start(); bus.if_read = 1'b1; bus.if_addr = 32'hFFFF_FFFE;
    wait_ready(1'b1, at);
    check("wrap_latency", 32'(at), 32'd6);
    for (int k = 0; k < 4; k++) check($sformatf("wrap_addr%0d", k), hist_a[k+2], wrap_a[k]);
    check("wrap_data", bus.if_data, 32'h0403_0201);
    bus.if_read = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
